uart_tx_arbiter: RTL and testbench

Shares one byte-level UART transmitter between N_REQ independent requesters. Each requester offers one byte at a time through a req/ack handshake. The arbiter grants round-robin and holds a grant across consecutive bytes (a burst) until the requester drops req or MAX_BURST is reached. It drives the transmitter's start/data inputs, watches its busy flag to sequence frames back-to-back, and flags a transmitter that never goes busy.

---
 rtl/uart_tx_arbiter.sv | 163 ++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one byte-level UART transmitter among N_REQ requesters,
// with per-owner burst locking and a watchdog on the transmitter's busy handshake.
module uart_tx_arbiter #(
    parameter int unsigned N_REQ        = 4,
    parameter int unsigned MAX_BURST    = 16,
    parameter int unsigned BUSY_TIMEOUT = 1000
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [N_REQ-1:0]     req,
    input  logic [8*N_REQ-1:0]   data_in,
    output logic [N_REQ-1:0]     ack,
    output logic [N_REQ-1:0]     grant,
    output logic                 tx_start,
    output logic [7:0]           tx_data,
    input  logic                 tx_busy,
    output logic                 err_timeout
);
    localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int unsigned BC_W  = $clog2(MAX_BURST + 1);
    localparam int unsigned TO_W  = (BUSY_TIMEOUT > 1) ? $clog2(BUSY_TIMEOUT) : 1;

    typedef enum logic [1:0] {IDLE, WAIT_BUSY, WAIT_DONE} state_e;

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   rr_q, rr_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [BC_W-1:0]    burst_cnt_q, burst_cnt_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [N_REQ-1:0]   ack_q, ack_d;
    logic [N_REQ-1:0]   grant_q, grant_d;
    logic               tx_start_q, tx_start_d;
    logic [7:0]         tx_data_q, tx_data_d;
    logic               err_q, err_d;
    logic               issue_en;
    logic [IDX_W-1:0]   issue_w;
    logic [IDX_W:0]     pick_rr, pick_rel;

    function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
        return (i == IDX_W'(N_REQ - 1)) ? '0 : IDX_W'(i + 1'b1);
    endfunction

    // Returns {found, index} of the first set request scanning from ptr with wrap.
    function automatic logic [IDX_W:0] pick(input logic [N_REQ-1:0] r,
                                            input logic [IDX_W-1:0] ptr);
        logic [IDX_W:0]   res;
        logic [IDX_W-1:0] idx;
        res = '0;
        idx = ptr;
        for (int unsigned k = 0; k < N_REQ; k++) begin
            if (r[idx] && !res[IDX_W]) begin
                res = {1'b1, idx};
            end
            idx = next_idx(idx);
        end
        return res;
    endfunction

    assign pick_rr  = pick(req, rr_q);
    assign pick_rel = pick(req, next_idx(owner_q));

    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        owner_d     = owner_q;
        burst_cnt_d = burst_cnt_q;
        to_cnt_d    = to_cnt_q;
        ack_d       = '0;
        grant_d     = grant_q;
        tx_start_d  = 1'b0;
        tx_data_d   = tx_data_q;
        err_d       = err_q;
        issue_en    = 1'b0;
        issue_w     = owner_q;

        case (state_q)
            IDLE: begin
                grant_d = '0;
                if (pick_rr[IDX_W]) begin
                    issue_en    = 1'b1;
                    issue_w     = pick_rr[IDX_W-1:0];
                    burst_cnt_d = BC_W'(1);
                end
            end
            WAIT_BUSY: begin
                if (tx_busy) begin
                    state_d = WAIT_DONE;
                end else if (to_cnt_q == TO_W'(BUSY_TIMEOUT - 1)) begin
                    err_d   = 1'b1;
                    grant_d = '0;
                    rr_d    = next_idx(owner_q);
                    state_d = IDLE;
                end else begin
                    to_cnt_d = TO_W'(to_cnt_q + 1'b1);
                end
            end
            WAIT_DONE: begin
                // Frame finished: extend the burst or hand over with zero idle cycles.
                if (!tx_busy) begin
                    if (req[owner_q] && (burst_cnt_q < BC_W'(MAX_BURST))) begin
                        issue_en    = 1'b1;
                        issue_w     = owner_q;
                        burst_cnt_d = BC_W'(burst_cnt_q + 1'b1);
                    end else begin
                        rr_d = next_idx(owner_q);
                        if (pick_rel[IDX_W]) begin
                            issue_en    = 1'b1;
                            issue_w     = pick_rel[IDX_W-1:0];
                            burst_cnt_d = BC_W'(1);
                        end else begin
                            grant_d = '0;
                            state_d = IDLE;
                        end
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        if (issue_en) begin
            owner_d    = issue_w;
            grant_d    = N_REQ'(1) << issue_w;
            ack_d      = N_REQ'(1) << issue_w;
            tx_data_d  = data_in[{issue_w, 3'b000} +: 8];
            tx_start_d = 1'b1;
            to_cnt_d   = '0;
            state_d    = WAIT_BUSY;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            rr_q        <= '0;
            owner_q     <= '0;
            burst_cnt_q <= '0;
            to_cnt_q    <= '0;
            ack_q       <= '0;
            grant_q     <= '0;
            tx_start_q  <= 1'b0;
            tx_data_q   <= 8'h00;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            owner_q     <= owner_d;
            burst_cnt_q <= burst_cnt_d;
            to_cnt_q    <= to_cnt_d;
            ack_q       <= ack_d;
            grant_q     <= grant_d;
            tx_start_q  <= tx_start_d;
            tx_data_q   <= tx_data_d;
            err_q       <= err_d;
        end
    end

    assign ack         = ack_q;
    assign grant       = grant_q;
    assign tx_start    = tx_start_q;
    assign tx_data     = tx_data_q;
    assign err_timeout = err_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: cycle table, directed multi-cycle sequences, and a
// randomized run against a transaction-level scheduling model with a byte scoreboard.
module tb_uart_tx_arbiter;
    localparam int N  = 4;
    localparam int MB = 4;
    localparam int BT = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req;
    logic [31:0] data_in;
    logic [3:0]  ack;
    logic [3:0]  grant;
    logic        tx_start;
    logic [7:0]  tx_data;
    logic        tx_busy_r;
    logic        err_timeout;

    int checks = 0;
    int errors = 0;

    uart_tx_arbiter #(.N_REQ(N), .MAX_BURST(MB), .BUSY_TIMEOUT(BT)) dut (
        .clk(clk), .rst(rst), .req(req), .data_in(data_in), .ack(ack), .grant(grant),
        .tx_start(tx_start), .tx_data(tx_data), .tx_busy(tx_busy_r), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [3:0]  req;
        logic [31:0] data;
        logic        busy;
        logic [3:0]  ack;
        logic [3:0]  grant;
        logic        start;
        logic [7:0]  txd;
    } vec_t;
    vec_t tbl[$];

    // transmitter model state
    bit tx_auto = 0;
    bit tx_rand = 0;
    int tx_len_fix = 3;
    int tx_len = 0;
    int tx_wait = 0;
    int tx_left = 0;

    // scheduling reference model
    bit         mdl_on = 0;
    bit         m_active, m_risen;
    int         m_owner, m_bc, m_rr, m_wait;
    logic [3:0] e_ack, e_grant;
    logic       e_start, e_err;
    logic [7:0] e_txd;

    logic [3:0] bo_exp [7];
    logic [7:0] bd_exp [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic add(input logic r, input logic [3:0] rq, input logic [31:0] d, input logic b,
                       input logic [3:0] a, input logic [3:0] g, input logic s, input logic [7:0] t);
        vec_t x;
        x.rst = r; x.req = rq; x.data = d; x.busy = b;
        x.ack = a; x.grant = g; x.start = s; x.txd = t;
        tbl.push_back(x);
    endtask

    function automatic int pick(input logic [3:0] r, input int from);
        for (int k = 0; k < N; k++) begin
            if (r[(from + k) % N]) return (from + k) % N;
        end
        return -1;
    endfunction

    task automatic m_issue(input int w, input int bc);
        m_active = 1; m_risen = 0; m_wait = 0; m_owner = w; m_bc = bc;
        e_ack = 4'(1 << w); e_grant = 4'(1 << w); e_start = 1'b1;
        e_txd = 8'(data_in >> (8 * w));
    endtask

    // One clock edge of the arbitration rules, applied to the inputs the DUT samples.
    task automatic model_edge();
        int w;
        e_ack = 4'b0; e_start = 1'b0;
        if (rst) begin
            m_active = 0; m_rr = 0; m_bc = 0; e_grant = 4'b0; e_txd = 8'h00; e_err = 1'b0;
        end else if (!m_active) begin
            w = pick(req, m_rr);
            if (w >= 0) m_issue(w, 1);
        end else if (!m_risen) begin
            if (tx_busy_r) m_risen = 1;
            else begin
                m_wait++;
                if (m_wait == BT) begin
                    e_err = 1'b1; m_active = 0; m_rr = (m_owner + 1) % N; e_grant = 4'b0;
                end
            end
        end else if (!tx_busy_r) begin
            if (req[m_owner] && m_bc < MB) m_issue(m_owner, m_bc + 1);
            else begin
                m_rr = (m_owner + 1) % N;
                w = pick(req, m_rr);
                if (w >= 0) m_issue(w, 1);
                else begin m_active = 0; e_grant = 4'b0; end
            end
        end
    endtask

    task automatic tx_model();
        int dly;
        if (!tx_auto) return;
        if (tx_left > 0) begin
            tx_left--;
            if (tx_left == 0) tx_busy_r = 1'b0;
        end
        if (tx_wait > 0) begin
            tx_wait--;
            if (tx_wait == 0) begin tx_busy_r = 1'b1; tx_left = tx_len; end
        end
        if (tx_start === 1'b1) begin
            tx_len = tx_rand ? int'($urandom_range(1, 4)) : tx_len_fix;
            dly    = tx_rand ? int'($urandom_range(0, 2)) : 1;
            if (dly == 0) begin tx_busy_r = 1'b1; tx_left = tx_len; end
            else tx_wait = dly;
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (mdl_on) model_edge();
        @(negedge clk);
        if (mdl_on) begin
            chk("m_ack", ack, e_ack);
            chk("m_grant", grant, e_grant);
            chk("m_start", tx_start, e_start);
            chk("m_txd", tx_data, e_txd);
            chk("m_err", err_timeout, e_err);
        end
        tx_model();
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while ((grant !== 4'b0 || tx_busy_r) && n < 100) begin step(); n++; end
        chk(name, grant, 4'b0);
    endtask

    task automatic wait_start(input string name, input logic [3:0] eg, input logic [7:0] ed);
        int n = 0;
        do begin step(); n++; end while (tx_start !== 1'b1 && n < 100);
        chk({name, "_start"}, tx_start, 1'b1);
        chk({name, "_grant"}, grant, eg);
        chk({name, "_ack"}, ack, eg);
        chk({name, "_data"}, tx_data, ed);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got running expected done");
        $fatal(1);
    end

    initial begin
        logic [3:0] got_o[$];
        logic [7:0] got_d[$];
        logic [7:0] cur [4];
        int k1;

        rst = 1'b1; req = 4'b0; data_in = 32'h0; tx_busy_r = 1'b0;
        step(); step();
        chk("rst_ack", ack, 4'b0);
        chk("rst_grant", grant, 4'b0);
        chk("rst_start", tx_start, 1'b0);
        chk("rst_txd", tx_data, 8'h00);
        chk("rst_err", err_timeout, 1'b0);
        rst = 1'b0;

        // single byte from requester 2, then release leaves rr at 3
        add(0, 4'b0100, 32'h0041_0000, 0, 4'b0100, 4'b0100, 1, 8'h41);
        add(0, 4'b0000, 32'h0041_0000, 0, 4'b0000, 4'b0100, 0, 8'h41);
        add(0, 4'b0000, 32'h0041_0000, 1, 4'b0000, 4'b0100, 0, 8'h41);
        add(0, 4'b0000, 32'h0041_0000, 1, 4'b0000, 4'b0100, 0, 8'h41);
        add(0, 4'b0000, 32'h0041_0000, 0, 4'b0000, 4'b0000, 0, 8'h41);
        add(0, 4'b0000, 32'h0041_0000, 0, 4'b0000, 4'b0000, 0, 8'h41);
        // contention with rr=3: order 3,0,1, back-to-back
        add(0, 4'b1011, 32'hD300_B1A0, 0, 4'b1000, 4'b1000, 1, 8'hD3);
        add(0, 4'b0011, 32'hD300_B1A0, 1, 4'b0000, 4'b1000, 0, 8'hD3);
        add(0, 4'b0011, 32'hD300_B1A0, 0, 4'b0001, 4'b0001, 1, 8'hA0);
        add(0, 4'b0010, 32'hD300_B1A0, 1, 4'b0000, 4'b0001, 0, 8'hA0);
        add(0, 4'b0010, 32'hD300_B1A0, 0, 4'b0010, 4'b0010, 1, 8'hB1);
        add(0, 4'b0000, 32'hD300_B1A0, 1, 4'b0000, 4'b0010, 0, 8'hB1);
        add(0, 4'b0000, 32'hD300_B1A0, 0, 4'b0000, 4'b0000, 0, 8'hB1);
        // reset, then contention from rr=0: order 0,1,3
        add(1, 4'b0000, 32'hD300_B1A0, 0, 4'b0000, 4'b0000, 0, 8'h00);
        add(0, 4'b1011, 32'hD300_B1A0, 0, 4'b0001, 4'b0001, 1, 8'hA0);
        add(0, 4'b1010, 32'hD300_B1A0, 1, 4'b0000, 4'b0001, 0, 8'hA0);
        add(0, 4'b1010, 32'hD300_B1A0, 0, 4'b0010, 4'b0010, 1, 8'hB1);
        add(0, 4'b1000, 32'hD300_B1A0, 1, 4'b0000, 4'b0010, 0, 8'hB1);
        add(0, 4'b1000, 32'hD300_B1A0, 0, 4'b1000, 4'b1000, 1, 8'hD3);
        add(0, 4'b0000, 32'hD300_B1A0, 1, 4'b0000, 4'b1000, 0, 8'hD3);
        add(0, 4'b0000, 32'hD300_B1A0, 0, 4'b0000, 4'b0000, 0, 8'hD3);
        // requester 3 bursts two bytes, drops; requester 0 next with rr wrapping to 0
        add(0, 4'b1000, 32'h3100_00A0, 0, 4'b1000, 4'b1000, 1, 8'h31);
        add(0, 4'b1001, 32'h3200_00A0, 1, 4'b0000, 4'b1000, 0, 8'h31);
        add(0, 4'b1001, 32'h3200_00A0, 0, 4'b1000, 4'b1000, 1, 8'h32);
        add(0, 4'b0001, 32'h3200_00A0, 1, 4'b0000, 4'b1000, 0, 8'h32);
        add(0, 4'b0001, 32'h3200_00A0, 0, 4'b0001, 4'b0001, 1, 8'hA0);
        add(0, 4'b0000, 32'h3200_00A0, 1, 4'b0000, 4'b0001, 0, 8'hA0);
        add(0, 4'b0000, 32'h3200_00A0, 0, 4'b0000, 4'b0000, 0, 8'hA0);

        foreach (tbl[i]) begin
            rst = tbl[i].rst; req = tbl[i].req; data_in = tbl[i].data; tx_busy_r = tbl[i].busy;
            step();
            chk($sformatf("tbl%0d_ack", i), ack, tbl[i].ack);
            chk($sformatf("tbl%0d_grant", i), grant, tbl[i].grant);
            chk($sformatf("tbl%0d_start", i), tx_start, tbl[i].start);
            chk($sformatf("tbl%0d_txd", i), tx_data, tbl[i].txd);
            chk($sformatf("tbl%0d_err", i), err_timeout, 1'b0);
        end
        rst = 1'b0; req = 4'b0; tx_busy_r = 1'b0;

        // burst limit: requester 1 sends 6 bytes, requester 0 joins after the 2nd
        bo_exp = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0001, 4'b0010, 4'b0010};
        bd_exp = '{8'h10, 8'h11, 8'h12, 8'h13, 8'hE0, 8'h14, 8'h15};
        tx_auto = 1; tx_rand = 0; tx_len_fix = 3;
        k1 = 0;
        req = 4'b0010; data_in = 32'h0000_10E0;
        for (int cyc = 0; cyc < 300 && got_o.size() < 7; cyc++) begin
            step();
            if (tx_start === 1'b1) begin
                got_o.push_back(grant); got_d.push_back(tx_data);
                chk("burst_ack_eq_grant", ack, grant);
            end
            if (ack[1]) begin
                k1++;
                if (k1 == 6) req[1] = 1'b0;
                else data_in[15:8] = 8'(8'h10 + k1);
                if (k1 == 2) req[0] = 1'b1;
            end
            if (ack[0]) req[0] = 1'b0;
        end
        chk("burst_count", got_o.size(), 7);
        for (int i = 0; i < 7 && i < got_o.size(); i++) begin
            chk($sformatf("burst%0d_owner", i), got_o[i], bo_exp[i]);
            chk($sformatf("burst%0d_data", i), got_d[i], bd_exp[i]);
        end
        wait_idle("burst_idle");

        // timeout: transmitter never goes busy
        tx_auto = 0; tx_busy_r = 1'b0;
        req = 4'b0001; data_in = 32'h0000_0055;
        step();
        chk("to_start", tx_start, 1'b1);
        chk("to_grant0", grant, 4'b0001);
        chk("to_txd", tx_data, 8'h55);
        req = 4'b0;
        for (int k = 1; k < BT; k++) begin
            step();
            chk($sformatf("to_err_c%0d", k), err_timeout, 1'b0);
            chk($sformatf("to_grant_c%0d", k), grant, 4'b0001);
        end
        step();
        chk("to_err_set", err_timeout, 1'b1);
        chk("to_grant_clr", grant, 4'b0);
        chk("to_no_start", tx_start, 1'b0);
        req = 4'b0100; data_in = 32'h0077_0055;
        step();
        chk("to_new_start", tx_start, 1'b1);
        chk("to_new_grant", grant, 4'b0100);
        chk("to_new_txd", tx_data, 8'h77);
        chk("to_err_sticky", err_timeout, 1'b1);
        req = 4'b0;
        tx_busy_r = 1'b1; step();
        tx_busy_r = 1'b0; step();
        chk("to_release", grant, 4'b0);

        // reset mid-frame: first set rr=2 by serving requester 1 alone
        tx_auto = 1; tx_len_fix = 10;
        req = 4'b0010; data_in = 32'h0000_1100;
        wait_start("pre_r1", 4'b0010, 8'h11);
        req = 4'b0;
        wait_idle("pre_idle");
        req = 4'b0110; data_in = 32'h0022_1100;
        wait_start("pre_r2", 4'b0100, 8'h22);
        step(); step(); step();
        rst = 1'b1;
        step();
        chk("mid_rst_ack", ack, 4'b0);
        chk("mid_rst_grant", grant, 4'b0);
        chk("mid_rst_start", tx_start, 1'b0);
        chk("mid_rst_txd", tx_data, 8'h00);
        chk("mid_rst_err", err_timeout, 1'b0);
        rst = 1'b0;
        step();
        chk("post_rst_grant", grant, 4'b0010);
        chk("post_rst_start", tx_start, 1'b1);
        chk("post_rst_txd", tx_data, 8'h11);
        req = 4'b0100;
        wait_start("post_rst_r2", 4'b0100, 8'h22);
        req = 4'b0;
        wait_idle("post_rst_idle");

        // randomized traffic against the reference model and byte scoreboard
        tx_rand = 1; mdl_on = 1;
        rst = 1'b1; req = 4'b0;
        step();
        rst = 1'b0;
        for (int i = 0; i < N; i++) cur[i] = 8'h00;
        for (int cyc = 0; cyc < 4000; cyc++) begin
            step();
            for (int i = 0; i < N; i++) begin
                if (ack[i]) begin
                    chk($sformatf("sb_byte_r%0d", i), tx_data, cur[i]);
                    if ($urandom_range(0, 2) != 0) begin
                        cur[i] = 8'($urandom);
                        data_in[8*i +: 8] = cur[i];
                    end else begin
                        req[i] = 1'b0;
                    end
                end else if (!req[i] && $urandom_range(0, 3) == 0) begin
                    cur[i] = 8'($urandom);
                    data_in[8*i +: 8] = cur[i];
                    req[i] = 1'b1;
                end
            end
        end
        req = 4'b0;
        wait_idle("rnd_idle");
        mdl_on = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
